// File: rtl/icebreaker_7sd_pkg.sv
// Shared types and the hex-to-segment decode for the two-digit 7-segment sequencer.
// Segment patterns are active-low {G,F,E,D,C,B,A}.
package icebreaker_7sd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } sd_state_e;

    typedef struct packed {
        logic       blank;
        logic [7:0] data;
    } sd_msg_t;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/icebreaker_7sd_fifo.sv
// Synchronous message FIFO with wrap-around pointers; the extra pointer bit
// separates full from empty. No write-to-read bypass.
module icebreaker_7sd_fifo
    import icebreaker_7sd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  sd_msg_t                i_din,
    output sd_msg_t                o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    sd_msg_t        r_mem [DEPTH];
    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;
    logic           w_do_push;
    logic           w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level = r_wptr - r_rptr;

endmodule

// File: rtl/icebreaker_7sd_sequencer.sv
// Queues byte messages and shows each on the two-digit 7-segment PMOD for a fixed dwell,
// back-to-back when more are waiting, otherwise holding the last one.
module icebreaker_7sd_sequencer
    import icebreaker_7sd_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int DWELL_CYCLES = 24000000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [7:0]             i_wr_data,
    input  logic                   i_wr_blank,
    input  logic                   i_flush,
    output logic [6:0]             o_a,
    output logic [6:0]             o_b,
    output logic                   o_en,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int             CW       = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(DWELL_CYCLES - 1);

    sd_state_e      r_state;
    sd_state_e      w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [6:0]     r_a;
    logic [6:0]     r_b;
    logic           r_en;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    sd_msg_t        w_din;
    sd_msg_t        w_head;

    assign o_wr_ready = ~w_full & ~i_flush;
    assign w_push     = i_wr_valid & o_wr_ready;
    assign w_din      = '{blank: i_wr_blank, data: i_wr_data};

    icebreaker_7sd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = SHOW;
                end
            end
            SHOW: begin
                if (r_cnt == '0) begin
                    if (!w_empty) w_pop        = 1'b1;
                    else          w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = SHOW;
                end
            end
            default: w_state_next = IDLE;
        endcase
        // flush wins over any pop decided this cycle
        if (i_flush) begin
            w_pop        = 1'b0;
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_a   <= SEG_BLANK;
            r_b   <= SEG_BLANK;
            r_en  <= 1'b0;
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= CNT_LOAD;
            r_en  <= ~w_head.blank;
            if (!w_head.blank) begin
                r_a <= hex7(w_head.data[7:4]);
                r_b <= hex7(w_head.data[3:0]);
            end
        end else if (r_state == SHOW && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_a    = r_a;
    assign o_b    = r_b;
    assign o_en   = r_en;
    assign o_busy = (r_state == SHOW) | ~w_empty;

endmodule

// File: tb/tb_icebreaker_7sd_sequencer.sv
// Bench for the 7-segment sequencer: fixed vector table, hand-built corner sequences and
// random traffic, all checked against a queue-and-timestamp reference model.
module tb_icebreaker_7sd_sequencer;

    localparam int DEPTH = 4;
    localparam int DWELL = 8;

    logic       clk = 1'b0;
    logic       i_rst, i_wr_valid, i_wr_blank, i_flush;
    logic [7:0] i_wr_data;
    logic       o_wr_ready, o_en, o_busy;
    logic [6:0] o_a, o_b;
    logic [2:0] o_level;

    always #5 clk = ~clk;

    icebreaker_7sd_sequencer #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_wr_valid (i_wr_valid),
        .o_wr_ready (o_wr_ready),
        .i_wr_data  (i_wr_data),
        .i_wr_blank (i_wr_blank),
        .i_flush    (i_flush),
        .o_a        (o_a),
        .o_b        (o_b),
        .o_en       (o_en),
        .o_busy     (o_busy),
        .o_level    (o_level)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] hexref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference model: pending messages, time of last pop, what the display shows
    logic [8:0] q[$];
    longint     t = 0;
    longint     last_pop = -1000;
    logic [6:0] m_a = 7'h7F;
    logic [6:0] m_b = 7'h7F;
    logic       m_en = 1'b0;
    logic       cur_flush = 1'b0;

    typedef struct {
        logic       r, v, bl, fl;
        logic [7:0] d;
        logic [6:0] ea, eb;
        logic       een;
        int         elev;
        logic       ebusy;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic r, logic v, logic [7:0] d, logic bl, logic fl,
                                logic [6:0] ea, logic [6:0] eb, logic een, int elev, logic ebusy);
        vec_t e;
        e.r = r; e.v = v; e.d = d; e.bl = bl; e.fl = fl;
        e.ea = ea; e.eb = eb; e.een = een; e.elev = elev; e.ebusy = ebusy;
        tbl.push_back(e);
    endfunction

    function automatic void addi(int n, logic [6:0] ea, logic [6:0] eb, logic een, int elev, logic ebusy);
        for (int k = 0; k < n; k++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ea, eb, een, elev, ebusy);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic bl, input logic fl, input logic [7:0] d);
        logic [8:0] m;
        logic       push;
        t++;
        if (r || fl) begin
            q.delete();
            m_a = 7'h7F; m_b = 7'h7F; m_en = 1'b0;
            last_pop = -1000;
        end else begin
            push = v && (q.size() < DEPTH);
            if (q.size() > 0 && (t - last_pop) >= DWELL) begin
                m = q.pop_front();
                m_en = ~m[8];
                if (!m[8]) begin
                    m_a = hexref[m[7:4]];
                    m_b = hexref[m[3:0]];
                end
                last_pop = t;
            end
            if (push) q.push_back({bl, d});
        end
    endtask

    task automatic model_check();
        chk("a", int'(o_a), int'(m_a));
        chk("b", int'(o_b), int'(m_b));
        chk("en", int'(o_en), int'(m_en));
        chk("level", int'(o_level), q.size());
        chk("wr_ready", int'(o_wr_ready), int'(q.size() < DEPTH && !cur_flush));
        chk("busy", int'(o_busy), int'(q.size() > 0 || (t - last_pop) < DWELL));
    endtask

    task automatic cycle(input logic r, input logic v, input logic bl, input logic fl,
                         input logic [7:0] d, output logic acc);
        logic rdy;
        i_rst = r; i_wr_valid = v; i_wr_blank = bl; i_flush = fl; i_wr_data = d;
        cur_flush = fl;
        @(negedge clk);
        rdy = o_wr_ready;
        @(posedge clk);
        #1;
        acc = v & rdy;
        model_step(r, v, bl, fl, d);
        model_check();
    endtask

    logic acc;
    int   waited;

    initial begin
        i_rst = 1'b1; i_wr_valid = 1'b0; i_wr_blank = 1'b0; i_flush = 1'b0; i_wr_data = 8'h00;

        // reset
        for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 7'h7F, 7'h7F, 1'b0, 0, 1'b0);
        addi(1, 7'h7F, 7'h7F, 1'b0, 0, 1'b0);
        // single message 3A, then HOLD
        add(1'b0, 1'b1, 8'h3A, 1'b0, 1'b0, 7'h7F, 7'h7F, 1'b0, 1, 1'b1);
        addi(8, 7'h30, 7'h08, 1'b1, 0, 1'b1);
        addi(2, 7'h30, 7'h08, 1'b1, 0, 1'b0);
        // back-to-back 12, 34
        add(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 7'h30, 7'h08, 1'b1, 1, 1'b1);
        add(1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 7'h79, 7'h24, 1'b1, 1, 1'b1);
        addi(7, 7'h79, 7'h24, 1'b1, 1, 1'b1);
        addi(8, 7'h30, 7'h19, 1'b1, 0, 1'b1);
        addi(2, 7'h30, 7'h19, 1'b1, 0, 1'b0);
        // FF, blank, 00
        add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 7'h30, 7'h19, 1'b1, 1, 1'b1);
        add(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 7'h0E, 7'h0E, 1'b1, 1, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 7'h0E, 7'h0E, 1'b1, 2, 1'b1);
        addi(6, 7'h0E, 7'h0E, 1'b1, 2, 1'b1);
        addi(8, 7'h0E, 7'h0E, 1'b0, 1, 1'b1);
        addi(8, 7'h40, 7'h40, 1'b1, 0, 1'b1);
        addi(2, 7'h40, 7'h40, 1'b1, 0, 1'b0);

        for (int k = 0; k < tbl.size(); k++) begin
            cycle(tbl[k].r, tbl[k].v, tbl[k].bl, tbl[k].fl, tbl[k].d, acc);
            chk($sformatf("tbl%0d_a", k), int'(o_a), int'(tbl[k].ea));
            chk($sformatf("tbl%0d_b", k), int'(o_b), int'(tbl[k].eb));
            chk($sformatf("tbl%0d_en", k), int'(o_en), int'(tbl[k].een));
            chk($sformatf("tbl%0d_level", k), int'(o_level), tbl[k].elev);
            chk($sformatf("tbl%0d_busy", k), int'(o_busy), int'(tbl[k].ebusy));
        end

        // overfill during SHOW: wr_valid held until each transfer
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, acc);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, acc);
        for (int k = 0; k <= DEPTH; k++) begin
            waited = 0;
            acc = 1'b0;
            while (!acc && waited < 40) begin
                cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hA1 + 8'(k), acc);
                waited++;
            end
            chk($sformatf("t4_push%0d_accepted", k), int'(acc), 1);
            if (k == DEPTH - 1) begin
                chk("t4_full_level", int'(o_level), DEPTH);
                chk("t4_ready_low", int'(o_wr_ready), 0);
            end
            if (k == DEPTH) chk("t4_last_waited", int'(waited > 1), 1);
        end
        for (int k = 0; k < 6 * DWELL; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, acc);
        chk("t4_drain_level", int'(o_level), 0);
        chk("t4_drain_busy", int'(o_busy), 0);
        chk("t4_last_a", int'(o_a), 7'h08);
        chk("t4_last_b", int'(o_b), 7'h12);

        // flush mid-SHOW with two queued and a concurrent push
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h61, acc);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h62, acc);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h63, acc);
        chk("t6_queued", int'(o_level), 2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, acc);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, acc);
        chk("t6_push_blocked", int'(acc), 0);
        chk("t6_a", int'(o_a), 7'h7F);
        chk("t6_b", int'(o_b), 7'h7F);
        chk("t6_en", int'(o_en), 0);
        chk("t6_level", int'(o_level), 0);
        chk("t6_busy", int'(o_busy), 0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, acc);
        chk("t6_stays_blank", int'(o_en), 0);

        // reset mid-SHOW
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h88, acc);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h99, acc);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, acc);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, acc);
        chk("t6r_a", int'(o_a), 7'h7F);
        chk("t6r_en", int'(o_en), 0);
        chk("t6r_level", int'(o_level), 0);
        chk("t6r_ready", int'(o_wr_ready), 1);
        chk("t6r_busy", int'(o_busy), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, acc);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(199) == 0), 1'($urandom_range(1)), ($urandom_range(7) == 0),
                  ($urandom_range(49) == 0), 8'($urandom), acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
